draw_player_dog: RTL
====================

// Module: draw_player_dog
// PURPOSE
//  Upstream driver and downstream consumer of the dog sprite ROM in the VGA draw chain.
//  Per pixel: tests whether (hcount,vcount) lies inside the dog box at (xpos,ypos),
//  drives the ROM address and the 2-bit frame select, then muxes the returned ROM
//  colour over the background. Transparent pixels pass the background colour through.
//  Frame select comes from an animation FSM: idle, walk (two frames), throw.
//  The FSM advances only at vsync rising edges, so no frame changes mid-screen.
// PARAMETERS
//  SPR_W        140     sprite width in px (SPR_W*SPR_H = 21140 words per frame)
//  SPR_H        151     sprite height in px
//  TRANSP       12'hF0F colour key treated as transparent
//  WALK_TICKS   8       vsync edges per walk frame toggle
//  THROW_TICKS  20      vsync edges the throw frame is held
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  hcount_in  in   11  horizontal pixel counter
//  vcount_in  in   11  vertical line counter
//  hsync_in/hblnk_in/vsync_in/vblnk_in  in  1 each  VGA timing
//  rgb_in     in   12  background colour
//  xpos       in   12  sprite top-left x (sampled every pixel)
//  ypos       in   12  sprite top-left y
//  walking    in   1   level: player moving
//  throw_req  in   1   pulse: start throw animation
//  rom_addr   out  15  ROM pixel address within frame
//  frame_sel  out  2   ROM frame: 0 idle/walkA, 1 walkB, 2 throw
//  rom_rgb    in   12  ROM data, valid 1 clk after rom_addr
//  hcount_out/vcount_out/hsync_out/hblnk_out/vsync_out/vblnk_out  out  timing delayed
//  rgb_out    out  12  composited colour
//  throwing   out  1   high while FSM is in THROW
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, tick counter 0, delay pipes cleared.
//  Pipeline: S1 registers in_box and rom_addr. The ROM registers rom_rgb (S2).
//   S3 registers rgb_out. Every timing signal is delayed exactly 3 clk.
//  in_box = hcount>=xpos && hcount<xpos+SPR_W && vcount>=ypos && vcount<ypos+SPR_H.
//   Compares use 13-bit unsigned sums so xpos+SPR_W never wraps.
//   A partially off-screen box draws only its visible part.
//  rom_addr = (vcount-ypos)*SPR_W + (hcount-xpos) when in_box, else 0.
//   Max value is 21139 and fits 15 bits. The multiply is constant and fits one stage.
//  rgb_out = rgb_in(delayed): if blanking (delayed), or !in_box(delayed), or rom_rgb==TRANSP.
//   Otherwise rgb_out = rom_rgb.
//  FSM (evaluated only on vsync_in rising edge, called a tick):
//   IDLE : frame 0. throw_req latched -> THROW. walking -> WALK.
//   WALK : frame toggles 0/1 every WALK_TICKS. !walking -> IDLE (frame 0).
//          latched throw -> THROW.
//   THROW: frame 2 for THROW_TICKS, then -> WALK if walking, else -> IDLE.
//  throw_req is latched on any clk. The latch clears when THROW is entered.
//   A request made during THROW is ignored, with no retrigger.
//  Throw and walk on the same tick: throw wins.
//  frame_sel is registered and changes only on the clk after a tick.
//  Reset mid-animation returns the FSM to IDLE at once; the pipeline is flushed to 0.
// STRUCTURE
//  players_pkg: DOG_W, DOG_H, DOG_IMAGE_SIZE, anim_state_t {IDLE,WALK,THROW},
//   frame codes FRAME_IDLE/FRAME_WALK_B/FRAME_THROW, TRANSP default.
//  Sub-module player_anim_fsm (tick detect, counter, state -> frame_sel).
//   It is reusable by draw_player_cat.
//  The draw datapath and delay pipes stay in this module.
// TESTING
//  1 Reset hold 3 clk with toggling inputs -> every output 0, frame_sel=0.
//  2 xpos=100,ypos=50, pixel (100,50) -> rom_addr=0. Pixel (239,200) -> 21139.
//    Pixel (240,50) -> out of box, rgb_out=rgb_in. All outputs 3 clk after the inputs.
//  3 ROM model returns TRANSP at addr 5 -> rgb_out=bg. Returns 12'h123 -> rgb_out=12'h123.
//    Blanking forces bg.
//  4 walking=1 for 40 vsync -> frame_sel 0,1,0,1,0 toggling every 8 ticks.
//    walking=0 -> frame 0 at next tick.
//  5 throw_req pulse mid-line while walking -> frame 2 after next tick, held 20 ticks.
//    A second pulse during THROW is ignored. Returns to WALK.
//  6 rst asserted during THROW -> next clk IDLE, throwing=0, frame_sel=0.

Source files
------------

// File: rtl/players_pkg.sv
// Shared constants and types for the player sprite drawers (dog, cat).
package players_pkg;

  localparam int DOG_W          = 140;
  localparam int DOG_H          = 151;
  localparam int DOG_IMAGE_SIZE = DOG_W * DOG_H;
  localparam int DOG_ADDR_W     = $clog2(DOG_IMAGE_SIZE);

  localparam logic [11:0] TRANSP_DEFAULT = 12'hF0F;

  localparam int WALK_TICKS_DEFAULT  = 8;
  localparam int THROW_TICKS_DEFAULT = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    THROW = 2'd2
  } anim_state_t;

  localparam logic [1:0] FRAME_IDLE   = 2'd0;
  localparam logic [1:0] FRAME_WALK_B = 2'd1;
  localparam logic [1:0] FRAME_THROW  = 2'd2;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } vga_timing_t;

endpackage

// File: rtl/player_anim_fsm.sv
// Sprite animation sequencer: advances only on vsync rising edges so the
// selected ROM frame never changes part-way through a screen.
//
//   state | meaning
//   IDLE  | standing still, frame 0
//   WALK  | walking, frame alternates 0/1 every WALK_TICKS ticks
//   THROW | throw frame held for THROW_TICKS ticks
module player_anim_fsm
  import players_pkg::*;
#(
  parameter int WALK_TICKS  = WALK_TICKS_DEFAULT,
  parameter int THROW_TICKS = THROW_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       walking,
  input  logic       throw_req,
  output logic [1:0] frame_sel,
  output logic       throwing
);

  localparam int MAX_TICKS = (WALK_TICKS > THROW_TICKS) ? WALK_TICKS : THROW_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] THROW_LOAD = CNT_W'(THROW_TICKS - 1);

  anim_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             walk_b_q, walk_b_d;
  logic             throw_pend_q, throw_pend_d;
  logic             vsync_q;
  logic [1:0]       frame_q, frame_d;
  logic             tick;
  logic             pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      walk_b_q     <= 1'b0;
      throw_pend_q <= 1'b0;
      vsync_q      <= 1'b0;
      frame_q      <= FRAME_IDLE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      walk_b_q     <= walk_b_d;
      throw_pend_q <= throw_pend_d;
      vsync_q      <= vsync;
      frame_q      <= frame_d;
    end
  end

  always_comb begin
    tick         = vsync & ~vsync_q;
    // a request arriving on the tick clock itself still counts
    pend         = throw_pend_q | throw_req;
    state_d      = state_q;
    cnt_d        = cnt_q;
    walk_b_d     = walk_b_q;
    throw_pend_d = throw_pend_q;
    frame_d      = FRAME_IDLE;

    if (throw_req && state_q != THROW) throw_pend_d = 1'b1;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (pend) begin
            state_d      = THROW;
            cnt_d        = THROW_LOAD;
            throw_pend_d = 1'b0;
          end else if (walking) begin
            state_d  = WALK;
            cnt_d    = WALK_LOAD;
            walk_b_d = 1'b0;
          end
        end
        WALK: begin
          if (pend) begin
            state_d      = THROW;
            cnt_d        = THROW_LOAD;
            throw_pend_d = 1'b0;
          end else if (!walking) begin
            state_d  = IDLE;
            walk_b_d = 1'b0;
          end else if (cnt_q == '0) begin
            walk_b_d = ~walk_b_q;
            cnt_d    = WALK_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        THROW: begin
          if (cnt_q == '0) begin
            walk_b_d = 1'b0;
            if (walking) begin
              state_d = WALK;
              cnt_d   = WALK_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    case (state_d)
      THROW:   frame_d = FRAME_THROW;
      WALK:    frame_d = walk_b_d ? FRAME_WALK_B : FRAME_IDLE;
      default: frame_d = FRAME_IDLE;
    endcase
  end

  assign frame_sel = frame_q;
  assign throwing  = (state_q == THROW);

endmodule

// File: rtl/draw_player_dog.sv
// Dog sprite drawer: box test and ROM address (S1), external ROM read (S2),
// colour-key composite over the background (S3). Timing is delayed to match.
module draw_player_dog
  import players_pkg::*;
#(
  parameter int          SPR_W       = DOG_W,
  parameter int          SPR_H       = DOG_H,
  parameter logic [11:0] TRANSP      = TRANSP_DEFAULT,
  parameter int          WALK_TICKS  = WALK_TICKS_DEFAULT,
  parameter int          THROW_TICKS = THROW_TICKS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  hblnk_in,
  input  logic                  vsync_in,
  input  logic                  vblnk_in,
  input  logic [11:0]           rgb_in,
  input  logic [11:0]           xpos,
  input  logic [11:0]           ypos,
  input  logic                  walking,
  input  logic                  throw_req,
  output logic [DOG_ADDR_W-1:0] rom_addr,
  output logic [1:0]            frame_sel,
  input  logic [11:0]           rom_rgb,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  hblnk_out,
  output logic                  vsync_out,
  output logic                  vblnk_out,
  output logic [11:0]           rgb_out,
  output logic                  throwing
);

  vga_timing_t           timing_in, timing_q1, timing_q2, timing_q3;
  logic [12:0]           h_ext, v_ext, x_ext, y_ext, dx, dy;
  logic                  in_box;
  logic [DOG_ADDR_W-1:0] addr_next, rom_addr_q;
  logic                  in_box_q1, in_box_q2;
  logic [11:0]           rgb_q1, rgb_q2, rgb_mix, rgb_out_q;
  logic                  use_bg;

  assign timing_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};

  // 13-bit sums so a box near the 12-bit limit never wraps around
  assign h_ext = {2'b00, hcount_in};
  assign v_ext = {2'b00, vcount_in};
  assign x_ext = {1'b0, xpos};
  assign y_ext = {1'b0, ypos};
  assign dx    = h_ext - x_ext;
  assign dy    = v_ext - y_ext;

  assign in_box = (h_ext >= x_ext) && (h_ext < x_ext + 13'(SPR_W)) &&
                  (v_ext >= y_ext) && (v_ext < y_ext + 13'(SPR_H));

  assign addr_next = in_box ?
                     DOG_ADDR_W'(dy) * DOG_ADDR_W'(SPR_W) + DOG_ADDR_W'(dx) :
                     '0;

  assign use_bg  = timing_q2.hblnk | timing_q2.vblnk | ~in_box_q2 | (rom_rgb == TRANSP);
  assign rgb_mix = use_bg ? rgb_q2 : rom_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      timing_q1  <= '0;
      timing_q2  <= '0;
      timing_q3  <= '0;
      rgb_q1     <= '0;
      rgb_q2     <= '0;
      in_box_q1  <= 1'b0;
      in_box_q2  <= 1'b0;
      rom_addr_q <= '0;
      rgb_out_q  <= '0;
    end else begin
      timing_q1  <= timing_in;
      timing_q2  <= timing_q1;
      timing_q3  <= timing_q2;
      rgb_q1     <= rgb_in;
      rgb_q2     <= rgb_q1;
      in_box_q1  <= in_box;
      in_box_q2  <= in_box_q1;
      rom_addr_q <= addr_next;
      rgb_out_q  <= rgb_mix;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rgb_out    = rgb_out_q;
  assign hcount_out = timing_q3.hcount;
  assign vcount_out = timing_q3.vcount;
  assign hsync_out  = timing_q3.hsync;
  assign hblnk_out  = timing_q3.hblnk;
  assign vsync_out  = timing_q3.vsync;
  assign vblnk_out  = timing_q3.vblnk;

  player_anim_fsm #(
    .WALK_TICKS  (WALK_TICKS),
    .THROW_TICKS (THROW_TICKS)
  ) u_anim (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync_in),
    .walking   (walking),
    .throw_req (throw_req),
    .frame_sel (frame_sel),
    .throwing  (throwing)
  );

endmodule
